if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline; producer end of the IF→ID interface.
- Generates the PC and issues requests on the SRAM-like instruction port (req/addr_ok/data_ok).
- Drives ic_to_id_bus and ic_inst from a one-entry output buffer that the ID stage samples.
- Handles branch redirect, pipeline flush and stalls; discards stale responses via a cancel counter.

Parameters:
- RESET_PC, 32'hbfc00000, PC loaded on reset.
- IC_TO_ID_WD, 34, width of ic_to_id_bus: [31:0]=pc, [32]=valid, [33]=adel.

Ports:
- clk  in  1  clock; one clock domain, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- stall  in  6  StallBus; stall[0]=freeze PC/request issue, stall[1]=ID not accepting.
- flush  in  1  exception flush; highest priority.
- new_pc  in  32  flush target.
- br_e  in  1  branch taken, resolved in EX.
- br_addr  in  32  branch target.
- inst_sram_req  out  1  fetch request.
- inst_sram_addr  out  32  fetch address.
- inst_sram_addr_ok  in  1  request accepted this cycle.
- inst_sram_data_ok  in  1  response valid this cycle; responses return in order.
- inst_sram_rdata  in  32  response instruction.
- ic_to_id_bus  out  IC_TO_ID_WD  {adel, valid, pc}.
- ic_inst  out  32  buffered instruction.
- stallreq  out  1  fetch bubble: ID is ready but no valid instruction is available.

Behaviour:
- Reset (async):
  - pc=RESET_PC, state=IDLE, cancel_cnt=0, out buffer cleared.
  - inst_sram_req=0, inst_sram_addr=RESET_PC, ic_to_id_bus=0, ic_inst=0, stallreq=0.
- States:
  - IDLE→REQ on the first edge after reset release.
  - REQ→WAIT on an accepted request.
  - WAIT→REQ on data_ok.
- Transfer: occurs at any edge with out_valid=1 and stall[1]=0. out_valid then clears unless refilled at the same edge.
- REQ:
  - inst_sram_req=1 iff ~stall[0] & (~out_valid | ~stall[1]) & cancel_cnt<3 & no redirect this cycle.
  - inst_sram_addr=pc, driven combinationally.
  - Accepted request (req & addr_ok) → WAIT.
  - Unaccepted requests may be withdrawn or changed.
- WAIT:
  - req=0.
  - On data_ok with cancel_cnt>0: decrement cancel_cnt, drop data, stay in WAIT.
  - On data_ok with cancel_cnt=0: load buffer {valid=1, pc, rdata}, pc←pc+4 (mod 2^32), →REQ.
- Redirect (flush, else br_e), any state:
  - pc←new_pc/br_addr, out_valid←0, next state REQ.
  - cancel_cnt increments (saturates at 3) if a request is outstanding past this edge, i.e. state=WAIT without data_ok, or REQ with addr_ok this cycle.
  - If data_ok arrives in the same cycle as the redirect, that data is dropped.
- flush and br_e together: flush wins.
- stallreq = (state==REQ|WAIT) & ~out_valid & ~stall[1] & ~flush & ~br_e.
- Output buffer: never overwritten while valid and stall[1]=1. The issue rule above guarantees this.
- cancel_cnt=3: new requests are inhibited until the count drains.

Optional Feature:
- Macro: IF_ADDR_ERR_EN.
- Defined:
  - In REQ with pc[1:0]≠0: no request issued.
  - Buffer loaded {adel=1, valid=1, pc, inst=0}; pc frozen until flush.
- Undefined:
  - ic_to_id_bus[33] tied 0.
  - inst_sram_addr[1:0] forced to 2'b00.

Test Plan:
- Release reset; addr_ok immediately, data_ok 1 cycle later, rdata=32'h24010001 → addr 32'hbfc00000, then bfc00004 requested. ID sees pc=bfc00000, inst=24010001, valid=1.
- Set stall[1]=1 for 3 cycles after the first fill → buffer held constant, inst_sram_req=0, no second request until stall[1] falls.
- br_e=1, br_addr=32'hbfc00100 while in WAIT; the stale data_ok arrives 2 cycles later → stale data dropped, cancel_cnt 1→0, next request addr=bfc00100.
- flush=1, new_pc=32'hbfc00380 together with br_e=1 → next request addr=bfc00380; out_valid=0.
- Assert rst asynchronously mid-WAIT → outputs zero immediately, inst_sram_req=0. The first request after release is bfc00000.
- (IF_ADDR_ERR_EN) br_addr=32'hbfc00102 → no inst_sram_req, bus[33]=1, valid=1, pc=bfc00102.

Source files
------------

// File: rtl/if_fetch.sv
// if_fetch: MIPS IF stage with SRAM-like fetch port, one-entry IF->ID buffer and stale-response cancel counter.
// Optional IF_ADDR_ERR_EN: misaligned PC raises adel in the buffer instead of issuing a fetch.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'hbfc00000,
  parameter int IC_TO_ID_WD = 34
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [5:0]             stall,
  input  logic                   flush,
  input  logic [31:0]            new_pc,
  input  logic                   br_e,
  input  logic [31:0]            br_addr,
  output logic                   inst_sram_req,
  output logic [31:0]            inst_sram_addr,
  input  logic                   inst_sram_addr_ok,
  input  logic                   inst_sram_data_ok,
  input  logic [31:0]            inst_sram_rdata,
  output logic [IC_TO_ID_WD-1:0] ic_to_id_bus,
  output logic [31:0]            ic_inst,
  output logic                   stallreq
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
  state_t state, state_nx;
  logic [31:0] pc, out_pc, out_inst, target;
  logic [1:0] cancel_cnt, cancel_nx;
  logic [2:0] cancel_sum;
  logic out_valid, out_adel, redirect, transfer, can_issue, issue, misalign, ld, ld_err, inc, dec;
  logic unused;
  assign unused = ^stall[5:2];
  assign redirect = flush | br_e;
  assign target = flush ? new_pc : br_addr;
  assign transfer = out_valid & ~stall[1];
  assign can_issue = (state == S_REQ) & ~stall[0] & (~out_valid | ~stall[1]) & ~redirect;
`ifdef IF_ADDR_ERR_EN
  assign misalign = pc[1:0] != 2'b00;
  assign inst_sram_addr = pc;
`else
  assign misalign = 1'b0;
  assign inst_sram_addr = {pc[31:2], 2'b00};
`endif
  assign issue = can_issue & (cancel_cnt != 2'd3) & ~misalign;
  assign ld = (state == S_WAIT) & inst_sram_data_ok & (cancel_cnt == 2'd0) & ~redirect;
  assign ld_err = can_issue & misalign;
  // a stale response drains the count; a redirect with a live request still in flight adds one
  assign dec = inst_sram_data_ok & (cancel_cnt != 2'd0);
  assign inc = redirect & (((state == S_WAIT) & ~(inst_sram_data_ok & (cancel_cnt == 2'd0)))
                           | ((state == S_REQ) & inst_sram_addr_ok));
  assign cancel_sum = {1'b0, cancel_cnt} + {2'b0, inc} - {2'b0, dec};
  assign cancel_nx = (cancel_sum > 3'd3) ? 2'd3 : cancel_sum[1:0];
  assign ic_to_id_bus = IC_TO_ID_WD'({out_adel, out_valid, out_pc});
  assign ic_inst = out_inst;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else state <= state_nx;
  always_comb
    state_nx = (state == S_IDLE || redirect) ? S_REQ :
               (issue && inst_sram_addr_ok) ? S_WAIT :
               ld ? S_REQ : state;
  always_comb begin
    inst_sram_req = issue;
    stallreq = (state != S_IDLE) & ~out_valid & ~stall[1] & ~redirect;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc <= RESET_PC;
      cancel_cnt <= 2'd0;
      out_valid <= 1'b0;
      out_adel <= 1'b0;
      out_pc <= 32'd0;
      out_inst <= 32'd0;
    end else begin
      cancel_cnt <= cancel_nx;
      pc <= redirect ? target : ld ? pc + 32'd4 : pc;
      if (redirect) out_valid <= 1'b0;
      else if (ld || ld_err) begin
        out_valid <= 1'b1;
        out_adel <= ld_err;
        out_pc <= pc;
        out_inst <= ld ? inst_sram_rdata : 32'd0;
      end else if (transfer) out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: random stimulus against a transaction-level model of the fetch stage and an in-order SRAM slave.
module tb_if_fetch;
  localparam logic [31:0] RESET_PC = 32'hbfc00000;
  logic clk = 1'b0, rst;
  logic [5:0] stall;
  logic flush, br_e, inst_sram_req, inst_sram_addr_ok, inst_sram_data_ok, stallreq;
  logic [31:0] new_pc, br_addr, inst_sram_addr, inst_sram_rdata, ic_inst;
  logic [33:0] ic_to_id_bus;
  int checks = 0, failures = 0, cyc = 0;
  always #5 clk = ~clk;

  if_fetch #(.RESET_PC(RESET_PC), .IC_TO_ID_WD(34)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
    .br_e(br_e), .br_addr(br_addr), .inst_sram_req(inst_sram_req),
    .inst_sram_addr(inst_sram_addr), .inst_sram_addr_ok(inst_sram_addr_ok),
    .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
    .ic_to_id_bus(ic_to_id_bus), .ic_inst(ic_inst), .stallreq(stallreq));

  // model: fetch PC, ID-side buffer, and the in-flight requests (1 = still wanted, 0 = discarded by a redirect)
  logic [31:0] m_pc, m_bpc, m_binst;
  bit m_started, m_bv, m_req, redirect;
  bit outq[$];
  logic [31:0] s_data[$];
  int s_rdy[$];

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int stale_cnt();
    int n = 0;
    foreach (outq[i]) if (!outq[i]) n++;
    return n;
  endfunction

  function automatic bit live();
    return outq.size() > 0 && outq[outq.size()-1];
  endfunction

  task automatic model_reset();
    m_pc = RESET_PC; m_bpc = 0; m_binst = 0; m_started = 0; m_bv = 0;
    outq.delete(); s_data.delete(); s_rdy.delete();
  endtask

  task automatic quiet();
    stall = 0; flush = 0; br_e = 0; new_pc = 0; br_addr = 0;
    inst_sram_addr_ok = 0; inst_sram_data_ok = 0; inst_sram_rdata = 0;
  endtask

  task automatic check_reset_outputs();
    check("rst_req", inst_sram_req, 0);
    check("rst_addr", inst_sram_addr, RESET_PC);
    check("rst_bus", ic_to_id_bus, 0);
    check("rst_inst", ic_inst, 0);
    check("rst_stallreq", stallreq, 0);
  endtask

  // one cycle, entered and left at a falling edge
  task automatic step();
    bit h;
    logic [31:0] d;
    cyc++;
    stall = ($urandom % 4 == 0) ? 6'($urandom) : 6'd0;
    flush = ($urandom % 25 == 0);
    br_e = ($urandom % 12 == 0);
    new_pc = $urandom & ~32'd3;
    br_addr = $urandom & ~32'd3;
    inst_sram_data_ok = s_rdy.size() > 0 && s_rdy[0] <= cyc && ($urandom % 4 != 0);
    inst_sram_rdata = inst_sram_data_ok ? s_data[0] : $urandom;
    redirect = flush | br_e;
    m_req = m_started && !live() && !stall[0] && (!m_bv || !stall[1]) && stale_cnt() < 3 && !redirect;
    inst_sram_addr_ok = m_req && ($urandom % 3 != 0);
    #1;
    check("req", inst_sram_req, m_req);
    check("addr", inst_sram_addr, m_pc);
    check("stallreq", stallreq, m_started && !m_bv && !stall[1] && !redirect);
    check("valid", ic_to_id_bus[32], m_bv);
    if (m_bv) begin
      check("bus", ic_to_id_bus, {2'b01, m_bpc});
      check("inst", ic_inst, m_binst);
    end
    @(posedge clk);
    if (m_bv && !stall[1]) m_bv = 0;
    if (inst_sram_data_ok) begin
      h = outq.pop_front();
      d = s_data.pop_front();
      void'(s_rdy.pop_front());
      if (h && !redirect) begin
        m_bv = 1; m_bpc = m_pc; m_binst = d; m_pc = m_pc + 4;
      end
    end
    if (inst_sram_addr_ok) begin
      outq.push_back(1);
      s_data.push_back($urandom);
      s_rdy.push_back(cyc + 1 + int'($urandom % 4));
    end
    if (redirect) begin
      foreach (outq[i]) outq[i] = 0;
      m_pc = flush ? new_pc : br_addr;
      m_bv = 0;
    end
    m_started = 1;
    @(negedge clk);
  endtask

  initial begin
    int n;
    quiet();
    model_reset();
    rst = 1;
    #1 check_reset_outputs();
    repeat (3) @(negedge clk);
    rst = 0;
    repeat (1500) step();
    // reset asynchronously while a live fetch is outstanding
    n = 0;
    while (!live() && n < 200) begin step(); n++; end
    check("wait_live_timeout", live(), 1);
    #2 rst = 1;
    quiet();
    #1 check_reset_outputs();
    model_reset();
    @(negedge clk);
    check("rst_hold_req", inst_sram_req, 0);
    rst = 0;
    repeat (1500) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
